dram_ctrl: RTL
==============

# dram_ctrl

Two-port memory controller that sits between the CPU and the byte-wide `DRAM` on the motherboard bus. It accepts word and sub-word requests from an instruction-fetch port and a data port, and arbitrates between them round-robin. Each request is sequenced into 1–4 little-endian single-byte `DRAM` beats. Reads are reassembled into a 32-bit response; writes get a one-cycle acknowledge.

## Interface
- `ADDR_WIDTH`, 32: byte address width, matching the `DRAM` address bus.
- `clk`  in  1: single system clock; all state updates on posedge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `i_req_valid`  in  1: fetch request; always an aligned word read.
- `i_req_ready`  out  1: fetch request accepted this cycle.
- `i_addr`  in  ADDR_WIDTH: fetch byte address.
- `i_rsp_valid`  out  1: one-cycle pulse; `i_rdata` and `i_err` are valid.
- `i_rdata`  out  32: fetched word.
- `i_err`  out  1: misaligned fetch (`i_addr[1:0]!=0`).
- `d_req_valid`  in  1: data request.
- `d_req_ready`  out  1: data request accepted this cycle.
- `d_we`  in  1: 1 = store, 0 = load.
- `d_size`  in  2: access size; 00 = byte, 01 = half, 10 = word, 11 = reserved (error).
- `d_addr`  in  ADDR_WIDTH: data byte address.
- `d_wdata`  in  32: store data, right-justified.
- `d_rsp_valid`  out  1: one-cycle pulse.
- `d_rdata`  out  32: load data, zero-extended; 0 for stores and errors.
- `d_err`  out  1: misaligned access or reserved size.
- `mem_addr`  out  ADDR_WIDTH: to `DRAM` `addr`.
- `mem_wdata`  out  8: to `DRAM` `wdata`.
- `mem_we`  out  1: to `DRAM` `write_enable`.
- `mem_rdata`  in  8: from `DRAM` `rdata` (combinational read).

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE.** Ready is asserted only here, and only for the granted port. Ready depends combinationally on the valids.
- **Arbitration.** A single valid port is granted. If both ports are valid, the grant goes to the port not granted last.
  - `last_grant` resets to I, so the first tie goes to D.
  - `last_grant` updates on every accept.
- **Accept.** On `valid & ready` the controller latches:
  - port, base address, we, beat count N (1/2/4), and write data.
- **Alignment and size check at accept.**
  - Error conditions: half with `addr[0]`; word with `addr[1:0]!=0`; `d_size==11`.
  - On error, go directly to RESP with err=1 and zero data. No `DRAM` beat is issued.
- **ACCESS.** Beat counter `cnt` runs 0..N-1, one beat per cycle.
  - `mem_addr = base + cnt`, computed modulo 2^ADDR_WIDTH.
  - Read beat: `mem_rdata` is captured at the posedge ending the beat into byte lane `cnt` (little-endian: lane 0 = bits 7:0).
  - Write beat: `mem_we=1`, `mem_wdata = wdata[8*cnt+7 : 8*cnt]`. The `DRAM` commits at the negedge inside the beat.
  - After beat N-1, go to RESP.
- **RESP.**
  - The owning port's `rsp_valid` pulses for one cycle with data and err.
  - The other port's rsp outputs are 0.
  - Next state is IDLE. There is no response backpressure.
- **Idle bus.** Outside ACCESS: `mem_we=0`, `mem_addr=0`, `mem_wdata=0`.
- **No input-to-output paths on the mem bus.** `mem_*` are decoded from registers only.

## Timing
- Accept at edge T. Beats occupy cycles T..T+N-1. `rsp_valid` is high in cycle T+N.
  - Word read: 5 cycles accept-to-response.
  - Byte op: 2 cycles.
  - Error: response in the cycle after accept.
- Next accept is possible at the edge ending RESP, i.e. back-to-back throughput of N+2 cycles per request.
- A request whose valid drops before it is accepted is not performed.
- **Reset values (all outputs):** 0, except `i_req_ready`/`d_req_ready`, which follow the IDLE rule after reset release.
- **Reset mid-operation:**
  - State returns asynchronously to IDLE and `mem_we` falls immediately.
  - Bytes already written remain in `DRAM`; there is no rollback.
  - No response is issued for the aborted request.

## Structure
- Shared header `mem_defs.vh` holds:
  - size codes (`SIZE_B`, `SIZE_H`, `SIZE_W`);
  - FSM state encoding;
  - beat-count function `size_to_beats`.
- Sub-module `mem_arbiter`: 2-way round-robin with a `last_grant` register and an `accept` input.
- `dram_ctrl` holds the FSM, beat counter, data assembly and lane select.

## Test plan
- Store word 0xDEADBEEF at 0x100, then load word at 0x100:
  - `mem_we` high for 4 cycles on 0x100–0x103 with bytes EF, BE, AD, DE;
  - `d_rdata=0xDEADBEEF`, response 5 cycles after accept.
- After the word store above, load byte at 0x102 → `d_rdata=0x000000AD`. Load half at 0x102 → `d_rdata=0x0000DEAD`.
- Misaligned accesses:
  - Load half at 0x101 → `d_err=1` in the next cycle, `mem_we` never asserted, no address beat.
  - Store word at 0x102 → same behaviour.
  - Fetch at 0x006 → `i_err=1`.
- Both ports valid from reset:
  - Grant order is D, I, D, I.
  - Exactly one ready per IDLE cycle; responses go only to the owning port.
- Store word 0x11223344 at 0x200; `rst_n` low during beat 2:
  - `mem_we` drops without a clock edge; no `d_rsp_valid`.
  - Subsequent load word 0x200 returns 0x00223344, assuming zeroed `DRAM`.
- Byte store at 0xFFFFFFFF → single beat on 0xFFFFFFFF; the controller is ready again 2 cycles later.

Source files
------------

// File: rtl/dram_ctrl_pkg.sv
// dram_ctrl_pkg: access-size codes, controller FSM states and the size-to-beat-count helper
package dram_ctrl_pkg;
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;
  function automatic logic [2:0] size_to_beats(input logic [1:0] size);
    return size == SIZE_H ? 3'd2 : size == SIZE_W ? 3'd4 : 3'd1;
  endfunction
endpackage

// File: rtl/dram_ctrl_arbiter.sv
// dram_ctrl_arbiter: 2-way round-robin (in: i_valid, d_valid, accept; out: gnt_i, gnt_d), ties go to the port not granted last
module dram_ctrl_arbiter (
  input  logic clk,
  input  logic rst_n,
  input  logic i_valid,
  input  logic d_valid,
  input  logic accept,
  output logic gnt_i,
  output logic gnt_d
);
  logic last_d_q, last_d_d;
  always_comb begin
    gnt_d = d_valid & (~i_valid | ~last_d_q);
    gnt_i = i_valid & ~gnt_d;
    last_d_d = accept ? gnt_d : last_d_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last_d_q <= 1'b0;
    else last_d_q <= last_d_d;
endmodule

// File: rtl/dram_ctrl.sv
// dram_ctrl: fetch (i_*) and data (d_*) request ports sequenced into little-endian byte beats on the DRAM bus (mem_*), 32-bit responses
module dram_ctrl import dram_ctrl_pkg::*; #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_req_valid,
  output logic                  i_req_ready,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_rsp_valid,
  output logic [31:0]           i_rdata,
  output logic                  i_err,
  input  logic                  d_req_valid,
  output logic                  d_req_ready,
  input  logic                  d_we,
  input  logic [1:0]            d_size,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [31:0]           d_wdata,
  output logic                  d_rsp_valid,
  output logic [31:0]           d_rdata,
  output logic                  d_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  output logic                  mem_we,
  input  logic [7:0]            mem_rdata
);
  state_t state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [2:0] beats_q, beats_d;
  logic port_q, port_d, we_q, we_d, err_q, err_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic gnt_i, gnt_d, accept, access, resp, last_beat, bad;
  logic [1:0] size;
  logic [ADDR_WIDTH-1:0] addr;
  dram_ctrl_arbiter u_arb (
    .clk(clk), .rst_n(rst_n), .i_valid(i_req_valid), .d_valid(d_req_valid),
    .accept(accept), .gnt_i(gnt_i), .gnt_d(gnt_d)
  );
  always_comb begin
    access = state_q == S_ACCESS;
    resp = state_q == S_RESP;
    i_req_ready = (state_q == S_IDLE) & gnt_i;
    d_req_ready = (state_q == S_IDLE) & gnt_d;
    accept = i_req_ready | d_req_ready;
    size = gnt_d ? d_size : SIZE_W;
    addr = gnt_d ? d_addr : i_addr;
    bad = (size == 2'b11) | ((size == SIZE_H) & addr[0]) | ((size == SIZE_W) & (addr[1:0] != 2'b00));
    last_beat = ({1'b0, cnt_q} + 3'd1) == beats_q;
    state_d = state_q;
    cnt_d = cnt_q;
    beats_d = beats_q;
    port_d = port_q;
    we_d = we_q;
    err_d = err_q;
    base_d = base_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    if (accept) begin
      port_d = gnt_d;
      base_d = addr;
      we_d = gnt_d & d_we;
      beats_d = size_to_beats(size);
      wdata_d = d_wdata;
      rdata_d = '0;
      err_d = bad;
      cnt_d = '0;
      state_d = bad ? S_RESP : S_ACCESS;
    end else if (access) begin
      if (!we_q) rdata_d[{cnt_q, 3'b000} +: 8] = mem_rdata;
      cnt_d = cnt_q + 2'd1;
      state_d = last_beat ? S_RESP : S_ACCESS;
    end else if (resp) state_d = S_IDLE;
    mem_we = access & we_q;
    mem_addr = access ? base_q + ADDR_WIDTH'(cnt_q) : '0;
    mem_wdata = mem_we ? wdata_q[{cnt_q, 3'b000} +: 8] : 8'h00;
    i_rsp_valid = resp & ~port_q;
    d_rsp_valid = resp & port_q;
    i_rdata = i_rsp_valid ? rdata_q : '0;
    d_rdata = d_rsp_valid ? rdata_q : '0;
    i_err = i_rsp_valid & err_q;
    d_err = d_rsp_valid & err_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      beats_q <= '0;
      port_q <= 1'b0;
      we_q <= 1'b0;
      err_q <= 1'b0;
      base_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      beats_q <= beats_d;
      port_q <= port_d;
      we_q <= we_d;
      err_q <= err_d;
      base_q <= base_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
endmodule
